// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared opcodes, link register and decode FSM encoding
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int LINK_REG = 31;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2
  } state_e;

endpackage

// File: rtl/register_bank.sv
// rtl/register_bank.sv - 2R1W register file, r0 hardwired to zero
// Optional WB_BYPASS_EN forwards the write port onto matching read ports.
module register_bank
  import dlx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int NREGS = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
`ifdef WB_BYPASS_EN
    if (wr_en && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (wr_en && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
`endif
  end

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - ID stage: PC alignment, decode, branch resolve, ID/EX register
// Build option WB_BYPASS_EN enables write-back bypass inside register_bank.
module instruction_decode
  import dlx_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruc_reg,
  input  logic [PC_W-1:0]   PC_plus_1,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              PC_sel,
  output logic [PC_W-1:0]   jump_address,
  output logic              ex_valid,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_funct,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic [PC_W-1:0]   ex_link_pc
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd, dest;
  logic [DATA_W-1:0] imm_ext, rs_data, rt_data;
  logic              cur_valid, is_rtype, is_j, is_jal, is_beq, is_bne, is_sw;
  logic              eq, take, reg_write;

  register_bank #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regs (
    .clock     (clock),
    .reset     (reset),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data)
  );

  assign opcode  = instruc_reg[31:26];
  assign funct   = instruc_reg[5:0];
  assign rs      = instruc_reg[21 +: REG_AW];
  assign rt      = instruc_reg[16 +: REG_AW];
  assign rd      = instruc_reg[11 +: REG_AW];
  assign imm_ext = {{(DATA_W-16){instruc_reg[15]}}, instruc_reg[15:0]};

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_sw    = (opcode == OP_SW);

  // Gating with reset keeps PC_sel low while reset is held in any state.
  assign cur_valid = (state_q == ST_RUN) && !reset;
  assign eq        = (rs_data == rt_data);
  assign take      = cur_valid && (is_j || is_jal || (is_beq && eq) || (is_bne && !eq));

  assign PC_sel = take;

  always_comb begin
    jump_address = '0;
    if (take) begin
      if (is_j || is_jal) jump_address = instruc_reg[PC_W-1:0];
      else                jump_address = pc_q + imm_ext[PC_W-1:0];
    end
  end

  always_comb begin
    dest = rt;
    if (is_rtype)    dest = rd;
    else if (is_jal) dest = REG_AW'(LINK_REG);
  end

  assign reg_write = !(is_sw || is_beq || is_bne || is_j) && (dest != '0) && cur_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    if (take) state_d = ST_SQUASH;
      ST_SQUASH: state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= '0;
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_dest      <= '0;
      ex_reg_write <= 1'b0;
      ex_link_pc   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= PC_plus_1;
      ex_valid     <= cur_valid;
      ex_opcode    <= opcode;
      ex_funct     <= funct;
      ex_rs_data   <= rs_data;
      ex_rt_data   <= rt_data;
      ex_imm       <= imm_ext;
      ex_dest      <= dest;
      ex_reg_write <= reg_write;
      ex_link_pc   <= pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - directed table-driven bench for instruction_decode
module tb_instruction_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruc_reg;
  logic [9:0]  PC_plus_1;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        PC_sel;
  logic [9:0]  jump_address;
  logic        ex_valid;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic [9:0]  ex_link_pc;

  int checks = 0;
  int errors = 0;

  instruction_decode dut (
    .clock        (clock),
    .reset        (reset),
    .instruc_reg  (instruc_reg),
    .PC_plus_1    (PC_plus_1),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .PC_sel       (PC_sel),
    .jump_address (jump_address),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .ex_funct     (ex_funct),
    .ex_rs_data   (ex_rs_data),
    .ex_rt_data   (ex_rt_data),
    .ex_imm       (ex_imm),
    .ex_dest      (ex_dest),
    .ex_reg_write (ex_reg_write),
    .ex_link_pc   (ex_link_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  pc;
    logic        sel;
    logic [9:0]  jump;
    logic [4:0]  dest;
    logic        rw;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[11];

  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  logic [31:0] exp_collide;

  initial begin
    vecs[0]  = '{32'h0800_0040, 10'h005, 1'b1, 10'h040, 5'd0,  1'b0, 32'd0, 32'd0, 32'h0000_0040};
    vecs[1]  = '{32'h1022_0003, 10'h010, 1'b1, 10'h013, 5'd2,  1'b0, 32'd7, 32'd7, 32'h0000_0003};
    vecs[2]  = '{32'h1024_0003, 10'h010, 1'b0, 10'h000, 5'd4,  1'b0, 32'd7, 32'd8, 32'h0000_0003};
    vecs[3]  = '{32'h1424_FFFE, 10'h005, 1'b1, 10'h003, 5'd4,  1'b0, 32'd7, 32'd8, 32'hFFFF_FFFE};
    vecs[4]  = '{32'h1422_FFFE, 10'h005, 1'b0, 10'h000, 5'd2,  1'b0, 32'd7, 32'd7, 32'hFFFF_FFFE};
    vecs[5]  = '{32'h0C00_0100, 10'h021, 1'b1, 10'h100, 5'd31, 1'b1, 32'd0, 32'd0, 32'h0000_0100};
    vecs[6]  = '{32'h1022_0002, 10'h3FF, 1'b1, 10'h001, 5'd2,  1'b0, 32'd7, 32'd7, 32'h0000_0002};
    vecs[7]  = '{32'h0024_2820, 10'h030, 1'b0, 10'h000, 5'd5,  1'b1, 32'd7, 32'd8, 32'h0000_2820};
    vecs[8]  = '{32'hAC24_0000, 10'h031, 1'b0, 10'h000, 5'd4,  1'b0, 32'd7, 32'd8, 32'h0000_0000};
    vecs[9]  = '{32'h2020_0001, 10'h032, 1'b0, 10'h000, 5'd0,  1'b0, 32'd7, 32'd0, 32'h0000_0001};
    vecs[10] = '{32'h8C26_0010, 10'h033, 1'b0, 10'h000, 5'd6,  1'b1, 32'd7, 32'd0, 32'h0000_0010};

    reset = 1'b1; instruc_reg = NOP; PC_plus_1 = 10'h000;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    tick();
    tick();
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_ex_link", 32'(ex_link_pc), 32'd0);
    check("rst_pc_sel", 32'(PC_sel), 32'd0);

    // Release reset with ADDI r1,r0,5: BOOT slot invalid, next slot valid.
    reset = 1'b0;
    instruc_reg = 32'h2001_0005;
    tick();
    check("boot_ex_valid", 32'(ex_valid), 32'd0);
    check("boot_ex_rw", 32'(ex_reg_write), 32'd0);
    tick();
    check("addi_ex_valid", 32'(ex_valid), 32'd1);
    check("addi_ex_dest", 32'(ex_dest), 32'd1);
    check("addi_ex_imm", ex_imm, 32'd5);
    check("addi_ex_rw", 32'(ex_reg_write), 32'd1);

    instruc_reg = NOP;
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    wb_write(5'd4, 32'd8);

    for (int i = 0; i < 11; i++) begin
      instruc_reg = NOP;
      PC_plus_1 = vecs[i].pc;
      tick();
      instruc_reg = vecs[i].instr;
      #1;
      check($sformatf("v%0d_pc_sel", i), 32'(PC_sel), 32'(vecs[i].sel));
      check($sformatf("v%0d_jump", i), 32'(jump_address), 32'(vecs[i].jump));
      tick();
      check($sformatf("v%0d_valid", i), 32'(ex_valid), 32'd1);
      check($sformatf("v%0d_dest", i), 32'(ex_dest), 32'(vecs[i].dest));
      check($sformatf("v%0d_rw", i), 32'(ex_reg_write), 32'(vecs[i].rw));
      check($sformatf("v%0d_rs", i), ex_rs_data, vecs[i].rs);
      check($sformatf("v%0d_rt", i), ex_rt_data, vecs[i].rt);
      check($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
      check($sformatf("v%0d_link", i), 32'(ex_link_pc), 32'(vecs[i].pc));
      if (vecs[i].sel) begin
        // Wrong-path slot: even a J must not redirect fetch.
        instruc_reg = 32'h0800_0055;
        #1;
        check($sformatf("v%0d_squash_sel", i), 32'(PC_sel), 32'd0);
        tick();
        check($sformatf("v%0d_squash_valid", i), 32'(ex_valid), 32'd0);
        check($sformatf("v%0d_squash_rw", i), 32'(ex_reg_write), 32'd0);
        instruc_reg = NOP;
        tick();
        check($sformatf("v%0d_after_valid", i), 32'(ex_valid), 32'd1);
      end
    end

    // Writes to r0 are dropped.
    instruc_reg = 32'h0000_3820;
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_FFFF;
    tick();
    wb_we = 1'b0;
    check("r0_same_cycle", ex_rs_data, 32'd0);
    tick();
    check("r0_after_write", ex_rs_data, 32'd0);

    // Same-cycle write/read of r3.
`ifdef WB_BYPASS_EN
    exp_collide = 32'h0000_A5A5;
`else
    exp_collide = 32'h0000_0000;
`endif
    instruc_reg = 32'h0063_3820;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_A5A5;
    tick();
    wb_we = 1'b0;
    check("r3_collide_rs", ex_rs_data, exp_collide);
    check("r3_collide_rt", ex_rt_data, exp_collide);
    tick();
    check("r3_after_write", ex_rs_data, 32'h0000_A5A5);

    // Reset during the SQUASH slot, with a concurrent write-back that must lose.
    PC_plus_1 = 10'h050;
    instruc_reg = 32'h0800_0040;
    #1;
    check("rs_sq_take", 32'(PC_sel), 32'd1);
    tick();
    reset = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_1234;
    #1;
    check("rs_sq_pc_sel", 32'(PC_sel), 32'd0);
    tick();
    wb_we = 1'b0;
    check("rs_sq_valid", 32'(ex_valid), 32'd0);
    check("rs_sq_opcode", 32'(ex_opcode), 32'd0);
    check("rs_sq_imm", ex_imm, 32'd0);
    check("rs_sq_dest", 32'(ex_dest), 32'd0);
    check("rs_sq_link", 32'(ex_link_pc), 32'd0);
    check("rs_sq_pc_sel2", 32'(PC_sel), 32'd0);
    reset = 1'b0;
    instruc_reg = 32'h0061_3820;
    #1;
    check("rs_boot_pc_sel", 32'(PC_sel), 32'd0);
    tick();
    check("rs_boot_valid", 32'(ex_valid), 32'd0);
    tick();
    check("rs_run_valid", 32'(ex_valid), 32'd1);
    check("rs_r3_cleared", ex_rs_data, 32'd0);
    check("rs_r1_cleared", ex_rt_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
